// File: rtl/stat_pkg.sv
// Shared types and constants for the CPU performance-statistics counters.
package stat_pkg;

    localparam int STAT_DEFAULT_WIDTH = 32;

    localparam logic [STAT_DEFAULT_WIDTH-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/stat_sat_counter.sv
// One statistics counter with synchronous clear.
// Builds with STAT_SATURATE_EN stick at all-ones; otherwise the count wraps.
module stat_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef STAT_SATURATE_EN
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
`endif

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear beats any increment arriving in the same cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
`ifdef STAT_SATURATE_EN
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
            end
`else
            count_d = count_q + CNT_ONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_stat_counter.sv
// Run-state tracker plus four event counters feeding the CPU statistics display.
// Define STAT_SATURATE_EN to make counters saturate instead of wrapping.
module cpu_stat_counter
    import stat_pkg::*;
#(
    parameter int WIDTH = STAT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             halt,
    input  logic             clear,
    input  logic             is_jump,
    input  logic             is_branch_taken,
    input  logic             loaduse_stall,
    output logic             running,
    output logic [WIDTH-1:0] all_time,
    output logic [WIDTH-1:0] j_change,
    output logic [WIDTH-1:0] loaduse,
    output logic [WIDTH-1:0] b_change_success
);

    state_t state_q;
    state_t state_d;
    logic   running_q;
    logic   countEn;

    // Halt wins over go while running; go wins over halt once halted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go)   state_d = RUN;
            RUN:     if (halt) state_d = HALTED;
            HALTED:  if (go)   state_d = RUN;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
        end
    end

    // The halting cycle itself is still counted, since state_q is RUN then.
    assign countEn = (state_q == RUN);
    assign running = running_q;

    stat_sat_counter #(.WIDTH(WIDTH)) uAllTime (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (countEn),
        .count (all_time)
    );

    stat_sat_counter #(.WIDTH(WIDTH)) uJump (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (countEn & is_jump),
        .count (j_change)
    );

    stat_sat_counter #(.WIDTH(WIDTH)) uLoadUse (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (countEn & loaduse_stall),
        .count (loaduse)
    );

    stat_sat_counter #(.WIDTH(WIDTH)) uBranch (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (countEn & is_branch_taken),
        .count (b_change_success)
    );

endmodule

// File: tb/tb_cpu_stat_counter.sv
// Directed self-checking bench for cpu_stat_counter, built with a 4-bit width
// so wrap/saturation at the counter limit is reachable in a few cycles.
module tb_cpu_stat_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         go;
    logic         halt;
    logic         clear;
    logic         isJump;
    logic         isBranchTaken;
    logic         loaduseStall;
    logic         running;
    logic [W-1:0] allTime;
    logic [W-1:0] jChange;
    logic [W-1:0] loaduseCnt;
    logic [W-1:0] bChange;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic         go;
        logic         halt;
        logic         clear;
        logic         jump;
        logic         br;
        logic         lu;
        logic         expRun;
        logic [W-1:0] expAll;
        logic [W-1:0] expJ;
        logic [W-1:0] expL;
        logic [W-1:0] expB;
    } vec_t;

    vec_t vecs[14];

    cpu_stat_counter #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .go               (go),
        .halt             (halt),
        .clear            (clear),
        .is_jump          (isJump),
        .is_branch_taken  (isBranchTaken),
        .loaduse_stall    (loaduseStall),
        .running          (running),
        .all_time         (allTime),
        .j_change         (jChange),
        .loaduse          (loaduseCnt),
        .b_change_success (bChange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let the edge happen and step just past it.
    task automatic applyStimulus(input logic r, input logic g, input logic h,
                                 input logic c, input logic j, input logic b,
                                 input logic l);
        reset         = r;
        go            = g;
        halt          = h;
        clear         = c;
        isJump        = j;
        isBranchTaken = b;
        loaduseStall  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string name, input string field,
                            input logic [W-1:0] act, input logic [W-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic expRun,
                               input logic [W-1:0] expAll, input logic [W-1:0] expJ,
                               input logic [W-1:0] expL, input logic [W-1:0] expB);
        checkOne(name, "running", {{(W-1){1'b0}}, running}, {{(W-1){1'b0}}, expRun});
        checkOne(name, "all_time", allTime, expAll);
        checkOne(name, "j_change", jChange, expJ);
        checkOne(name, "loaduse", loaduseCnt, expL);
        checkOne(name, "b_change_success", bChange, expB);
    endtask

    initial begin
        logic [W-1:0] expWrap;

        //                go   halt clr  jmp  br   lu   run  all j   l   b
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,  0,  0,  0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0,  0,  0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1,  1,  0,  0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2,  1,  0,  1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3,  1,  1,  1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4,  2,  1,  1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5,  2,  2,  1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6,  2,  2,  2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7,  2,  3,  2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8,  3,  3,  2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9,  3,  4,  2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3,  4,  2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10, 3,  4,  2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3,  4,  2};

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset", 1'b0, 0, 0, 0, 0);

        $display("[TB] table: run 10 cycles with strobes, halt on the 10th");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].go, vecs[i].halt, vecs[i].clear,
                          vecs[i].jump, vecs[i].br, vecs[i].lu);
            checkOutput($sformatf("vec%0d", i), vecs[i].expRun, vecs[i].expAll,
                        vecs[i].expJ, vecs[i].expL, vecs[i].expB);
        end

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("frozen20", 1'b0, 10, 3, 4, 2);

        $display("[TB] halt at 5, idle 7, resume for 4");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clearHalted", 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resumeGo", 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("haltAt5", 1'b0, 5, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("waited7", 1'b0, 5, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("goAgain", 1'b1, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("resumed4", 1'b1, 9, 0, 0, 0);

        $display("[TB] clear with jump while running");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clearRun", 1'b1, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("afterClear", 1'b1, 1, 0, 0, 0);

        $display("[TB] counter limit");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("preload14", 1'b1, 14, 14, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("atMax", 1'b1, 15, 15, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef STAT_SATURATE_EN
        expWrap = 4'd15;
`else
        expWrap = 4'd1;
`endif
        checkOutput("pastMax", 1'b1, expWrap, expWrap, 0, 0);

        $display("[TB] reset mid-run with go held");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("resetMidRun", 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("idleAfterReset", 1'b0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/cpu_stat_counter.md
# cpu_stat_counter

Performance-statistics producer for the single-cycle/pipelined CPU. Observes per-cycle event strobes from the datapath and hazard unit and maintains four running counts: total run cycles, unconditional jumps, load-use stalls and taken conditional branches. These counts drive the display-selection block's `all_time`, `j_change`, `loaduse` and `b_change_success` inputs. Counting follows the CPU run state (idle, running, halted by syscall), so the display shows stable values once the program stops.

## Interface
- `WIDTH`, 32, width of every counter and output
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk`
- `go`  in  1  single-cycle start/resume pulse (debounced button)
- `halt`  in  1  syscall-halt strobe from the datapath, valid in the same cycle as the instruction
- `clear`  in  1  synchronous counter clear, independent of state
- `is_jump`  in  1  unconditional jump (j/jal/jr) in execute this cycle
- `is_branch_taken`  in  1  conditional branch resolved taken this cycle
- `loaduse_stall`  in  1  hazard unit inserting a load-use bubble this cycle
- `running`  out  1  high while in RUN
- `all_time`  out  WIDTH  cycles spent in RUN
- `j_change`  out  WIDTH  unconditional jumps counted
- `loaduse`  out  WIDTH  load-use stall cycles counted
- `b_change_success`  out  WIDTH  taken conditional branches counted

## Operation
- States: IDLE, RUN, HALTED. Reset state IDLE.
- IDLE: `go`=1 -> RUN. Other inputs ignored except `clear`.
- RUN: `halt`=1 -> HALTED. `go` ignored.
- HALTED: `go`=1 -> RUN (resume without clearing). `halt` ignored.
- Counting is enabled only in RUN, including the cycle in which `halt` is sampled.
- In RUN, every cycle: `all_time` += 1. `j_change` += `is_jump`. `loaduse` += `loaduse_stall`. `b_change_success` += `is_branch_taken`.
- Event strobes are qualified by state only. The producer guarantees that `is_jump` and `is_branch_taken` are never high on a stalled cycle.
- `clear`=1: all four counters go to 0 on the next edge. `clear` overrides increments in the same cycle. State is unchanged.
- `running` = (state == RUN), registered.
- Overflow is governed by `STAT_SATURATE_EN` (see Configuration).

## Timing
- Reset (`reset`=0 at an edge): state IDLE, all counters 0, `running` 0. Reset takes priority over `clear`, `go` and `halt`, including mid-run.
- Outputs are direct register outputs. A strobe sampled at edge N is visible after edge N.
- `go` sampled at edge N in IDLE: `running`=1 after N. The first counted cycle is the one sampled at edge N+1, so `all_time`=1 after edge N+1.
- `halt` sampled at edge N in RUN: that cycle's events are counted, `running`=0 after N, and counters are frozen from N+1.
- `go` and `halt` together in RUN: halt wins. In HALTED: go wins.
- Held `go` is level-tolerant: RUN persists, and no double counting occurs.

## Configuration
- `STAT_SATURATE_EN` defined: each counter sticks at 2^WIDTH-1, and further increments are dropped.
- Not defined: counters wrap modulo 2^WIDTH, so 2^WIDTH-1 + 1 = 0.
- `clear` and `reset` behave identically in both builds.

## Structure
- Package `stat_pkg`:
  - state encoding IDLE=2'd0, RUN=2'd1, HALTED=2'd2
  - `STAT_MAX` all-ones constant
- Sub-module `stat_sat_counter`:
  - ports: clk, reset, clear, inc, count
  - parameterised by `WIDTH`, containing the saturate/wrap logic under the macro
  - instantiated four times
- The top level holds the FSM and the increment qualification.

## Test plan
- Reset, then `go` at cycle 0, run 10 cycles, `halt` on the 10th -> `all_time`=10, `running`=0, and the value stays 10 for 20 further cycles.
- In RUN, 3 `is_jump`, 2 `is_branch_taken`, 4 `loaduse_stall` pulses on distinct cycles -> `j_change`=3, `b_change_success`=2, `loaduse`=4. Strobes in IDLE/HALTED add 0.
- Halt at `all_time`=5, wait 7 cycles, `go`, run 4 cycles -> `all_time`=9.
- `clear` together with `is_jump` in RUN -> all counters 0 next cycle, `j_change`=0, state stays RUN, and `all_time`=1 one cycle later.
- Preload near max (WIDTH=4, 14 run cycles, then 3 more) -> 15 with `STAT_SATURATE_EN`, 1 without.
- `reset`=0 mid-RUN with counters nonzero -> all 0, IDLE, `running`=0. A simultaneous `go` is ignored.
